maze_out_arbiter: RTL and testbench

- QoS-aware 5:1 output-port arbiter for a MAZE mesh NODE.
- Shares one output link (local B port or one of N/W/S/E) between the five input sources, indexed 0=A (local), 1=N, 2=W, 3=S, 4=E.
- Round-robin within each QoS class, with starvation promotion of low-QoS requesters.
- Registers the winning single-flit packet into a one-entry output stage with valid/ready handshake.

---
 rtl/maze_out_arbiter.sv | 156 +++++++++++++++
 tb/tb_maze_out_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/maze_out_arbiter.sv
// maze_out_arbiter: QoS-aware 5:1 output-port arbiter for a MAZE mesh node.
// Sources 0=A(local),1=N,2=W,3=S,4=E compete for one output link. Two
// round-robin classes (hi = qos or starved, lo = rest), one-entry output
// register with valid/ready handshake.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   port_en      link enable; 0 blocks new grants (held packet still drains)
//   req_vld[5]   per-source packet valid
//   req_rdy[5]   per-source accept (combinational, one-hot or zero)
//   req_pkt      source i packet at [i*PKT_W +: PKT_W]
//   out_vld      output register holds a packet
//   out_rdy      downstream accept
//   out_pkt      registered packet
//   out_src      source index of the held packet
module maze_out_arbiter #(
   parameter int unsigned DW           = 8,
   parameter int unsigned PKT_W        = 15 + DW,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               port_en,
   input  logic [4:0]         req_vld,
   output logic [4:0]         req_rdy,
   input  logic [5*PKT_W-1:0] req_pkt,
   output logic               out_vld,
   input  logic               out_rdy,
   output logic [PKT_W-1:0]   out_pkt,
   output logic [2:0]         out_src
);

   localparam int unsigned NSRC    = 5;
   localparam int unsigned CW      = $clog2(STARVE_LIMIT + 1);
   localparam int unsigned QOS_BIT = PKT_W - 3;

   typedef logic [2:0] idx_t;

   // First set bit of vec searching upward from ptr, modulo 5; returns {found, idx}.
   function automatic logic [3:0] rr_pick(input logic [4:0] vec, input idx_t ptr);
      logic        found;
      idx_t        idx;
      int unsigned j;
      found = 1'b0;
      idx   = '0;
      for (int unsigned k = 0; k < NSRC; k++) begin
         j = (32'(ptr) + k) % NSRC;
         if (!found && vec[3'(j)]) begin
            found = 1'b1;
            idx   = idx_t'(j);
         end
      end
      return {found, idx};
   endfunction

   logic              out_vld_q, out_vld_d;
   logic [PKT_W-1:0]  out_pkt_q, out_pkt_d;
   idx_t              out_src_q, out_src_d;
   idx_t              rr_hi_q, rr_hi_d;
   idx_t              rr_lo_q, rr_lo_d;
   logic [CW-1:0]     wait_cnt_q [NSRC];
   logic [CW-1:0]     wait_cnt_d [NSRC];

   logic              load_ok;
   logic [4:0]        qos_c, hi_c, lo_c, grant_c;
   logic [3:0]        hi_pick, lo_pick;
   logic              win_vld;
   idx_t              win_idx, win_nxt;
   logic [PKT_W-1:0]  win_pkt;

   // Class split, winner selection, output stage and starvation counters.
   always_comb begin
      out_vld_d = out_vld_q;
      out_pkt_d = out_pkt_q;
      out_src_d = out_src_q;
      rr_hi_d   = rr_hi_q;
      rr_lo_d   = rr_lo_q;
      grant_c   = '0;
      win_pkt   = '0;
      for (int i = 0; i < NSRC; i++) begin
         wait_cnt_d[i] = wait_cnt_q[i];
      end

      load_ok = port_en && (!out_vld_q || out_rdy);

      for (int i = 0; i < NSRC; i++) begin
         qos_c[i] = req_pkt[i*PKT_W + QOS_BIT];
         hi_c[i]  = req_vld[i] && (qos_c[i] || (wait_cnt_q[i] == CW'(STARVE_LIMIT)));
         lo_c[i]  = req_vld[i] && !hi_c[i];
      end

      hi_pick = rr_pick(hi_c, rr_hi_q);
      lo_pick = rr_pick(lo_c, rr_lo_q);
      win_vld = hi_pick[3] || lo_pick[3];
      win_idx = hi_pick[3] ? hi_pick[2:0] : lo_pick[2:0];
      win_nxt = (win_idx == idx_t'(NSRC - 1)) ? idx_t'(0) : idx_t'(win_idx + idx_t'(1));

      // rst_n gate keeps req_rdy low for the whole reset interval.
      for (int i = 0; i < NSRC; i++) begin
         grant_c[i] = rst_n && load_ok && win_vld && (win_idx == idx_t'(i));
         if (grant_c[i]) begin
            win_pkt = req_pkt[i*PKT_W +: PKT_W];
         end
      end

      if (|grant_c) begin
         out_vld_d = 1'b1;
         out_pkt_d = win_pkt;
         out_src_d = win_idx;
         if (hi_pick[3]) begin
            rr_hi_d = win_nxt;
         end else begin
            rr_lo_d = win_nxt;
         end
      end else if (out_rdy) begin
         out_vld_d = 1'b0;
      end

      // Counters run independently of load_ok; qos=1 requesters hold their value.
      for (int i = 0; i < NSRC; i++) begin
         if (grant_c[i] || !req_vld[i]) begin
            wait_cnt_d[i] = '0;
         end else if (!qos_c[i] && (wait_cnt_q[i] != CW'(STARVE_LIMIT))) begin
            wait_cnt_d[i] = wait_cnt_q[i] + CW'(1);
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld_q <= 1'b0;
         out_pkt_q <= '0;
         out_src_q <= '0;
         rr_hi_q   <= '0;
         rr_lo_q   <= '0;
         for (int i = 0; i < NSRC; i++) begin
            wait_cnt_q[i] <= '0;
         end
      end else begin
         out_vld_q <= out_vld_d;
         out_pkt_q <= out_pkt_d;
         out_src_q <= out_src_d;
         rr_hi_q   <= rr_hi_d;
         rr_lo_q   <= rr_lo_d;
         for (int i = 0; i < NSRC; i++) begin
            wait_cnt_q[i] <= wait_cnt_d[i];
         end
      end
   end

   assign req_rdy = grant_c;
   assign out_vld = out_vld_q;
   assign out_pkt = out_pkt_q;
   assign out_src = out_src_q;

endmodule

// File: tb/tb_maze_out_arbiter.sv
// tb_maze_out_arbiter: directed self-checking bench for maze_out_arbiter.
module tb_maze_out_arbiter;

   localparam int unsigned DW    = 8;
   localparam int unsigned PKT_W = 15 + DW;

   logic               clk;
   logic               rst_n;
   logic               port_en;
   logic [4:0]         req_vld;
   logic [4:0]         req_rdy;
   logic [5*PKT_W-1:0] req_pkt;
   logic               out_vld;
   logic               out_rdy;
   logic [PKT_W-1:0]   out_pkt;
   logic [2:0]         out_src;

   int checks;
   int errors;

   maze_out_arbiter #(.DW(DW), .PKT_W(PKT_W), .STARVE_LIMIT(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .port_en (port_en),
      .req_vld (req_vld),
      .req_rdy (req_rdy),
      .req_pkt (req_pkt),
      .out_vld (out_vld),
      .out_rdy (out_rdy),
      .out_pkt (out_pkt),
      .out_src (out_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [PKT_W-1:0] mk(input logic q, input int s, input logic [7:0] d);
      return {2'b01, q, 6'(s), 6'h2A, d};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic set_pkt(input int i, input logic [PKT_W-1:0] p);
      req_pkt[i*PKT_W +: PKT_W] = p;
   endtask

   // Leaves the bench at a negedge with reset released.
   task automatic do_reset();
      rst_n   = 1'b0;
      req_vld = '0;
      req_pkt = '0;
      port_en = 1'b1;
      out_rdy = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   int rr_seq [5]  = '{1, 2, 3, 4, 1};
   int qos_seq [12] = '{2, 2, 2, 2, 2, 2, 2, 2, 0, 2, 4, 2};

   initial begin
      checks = 0;
      errors = 0;

      // Reset state and single source.
      do_reset();
      #1;
      chk("rst_out_vld", 32'(out_vld), 32'd0);
      chk("rst_out_pkt", 32'(out_pkt), 32'd0);
      chk("rst_out_src", 32'(out_src), 32'd0);
      chk("rst_req_rdy", 32'(req_rdy), 32'd0);
      set_pkt(0, mk(1'b0, 0, 8'hA5));
      req_vld = 5'b00001;
      #1;
      chk("single_rdy", 32'(req_rdy), 32'h01);
      chk("single_vld_pre", 32'(out_vld), 32'd0);
      @(negedge clk);
      req_vld = 5'b00000;
      #1;
      chk("single_vld", 32'(out_vld), 32'd1);
      chk("single_data", 32'(out_pkt[7:0]), 32'hA5);
      chk("single_pkt", 32'(out_pkt), 32'(mk(1'b0, 0, 8'hA5)));
      chk("single_src", 32'(out_src), 32'd0);
      chk("single_rdy_idle", 32'(req_rdy), 32'd0);
      @(negedge clk);
      #1;
      chk("single_drain", 32'(out_vld), 32'd0);

      // Round-robin among lo-class sources 1..4.
      do_reset();
      for (int i = 1; i < 5; i++) set_pkt(i, mk(1'b0, i, 8'(8'h10 + i)));
      req_vld = 5'b11110;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("rr_rdy", 32'(req_rdy), 32'(5'b00001 << rr_seq[k]));
         if (k > 0) begin
            chk("rr_vld", 32'(out_vld), 32'd1);
            chk("rr_src", 32'(out_src), 32'(rr_seq[k-1]));
         end
         @(negedge clk);
      end

      // QoS priority with starvation promotion of sources 0 and 4.
      do_reset();
      set_pkt(0, mk(1'b0, 0, 8'h20));
      set_pkt(2, mk(1'b1, 2, 8'h22));
      set_pkt(4, mk(1'b0, 4, 8'h24));
      req_vld = 5'b00101;
      for (int k = 0; k < 12; k++) begin
         if (k == 1) req_vld = 5'b10101;
         #1;
         chk("qos_rdy", 32'(req_rdy), 32'(5'b00001 << qos_seq[k]));
         if (k > 0) chk("qos_src", 32'(out_src), 32'(qos_seq[k-1]));
         @(negedge clk);
      end

      // Backpressure holds the output and blocks grants.
      do_reset();
      set_pkt(1, mk(1'b0, 1, 8'h31));
      set_pkt(3, mk(1'b0, 3, 8'h33));
      req_vld = 5'b01010;
      #1;
      chk("bp_first_rdy", 32'(req_rdy), 32'h02);
      @(negedge clk);
      out_rdy = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_rdy", 32'(req_rdy), 32'd0);
         chk("bp_vld", 32'(out_vld), 32'd1);
         chk("bp_src", 32'(out_src), 32'd1);
         chk("bp_pkt", 32'(out_pkt), 32'(mk(1'b0, 1, 8'h31)));
         @(negedge clk);
      end
      out_rdy = 1'b1;
      #1;
      chk("bp_release_rdy", 32'(req_rdy), 32'h08);
      @(negedge clk);
      #1;
      chk("bp_next_src", 32'(out_src), 32'd3);
      chk("bp_next_pkt", 32'(out_pkt), 32'(mk(1'b0, 3, 8'h33)));

      // port_en low: held packet drains, no grants; resume at rr_lo=0.
      do_reset();
      for (int i = 0; i < 5; i++) set_pkt(i, mk(1'b0, i, 8'(8'h40 + i)));
      req_vld = 5'b10000;
      out_rdy = 1'b0;
      #1;
      chk("pe_load_rdy", 32'(req_rdy), 32'h10);
      @(negedge clk);
      port_en = 1'b0;
      req_vld = 5'b11111;
      out_rdy = 1'b1;
      #1;
      chk("pe_held_vld", 32'(out_vld), 32'd1);
      chk("pe_held_src", 32'(out_src), 32'd4);
      chk("pe_off_rdy", 32'(req_rdy), 32'd0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         #1;
         chk("pe_drained", 32'(out_vld), 32'd0);
         chk("pe_off_rdy2", 32'(req_rdy), 32'd0);
      end
      @(negedge clk);
      port_en = 1'b1;
      #1;
      chk("pe_resume_rdy", 32'(req_rdy), 32'h01);
      @(negedge clk);
      #1;
      chk("pe_resume_vld", 32'(out_vld), 32'd1);
      chk("pe_resume_src", 32'(out_src), 32'd0);

      // Asynchronous reset in the middle of a held packet.
      do_reset();
      set_pkt(2, mk(1'b0, 2, 8'h52));
      set_pkt(3, mk(1'b0, 3, 8'h53));
      req_vld = 5'b01000;
      #1;
      chk("mr_rdy", 32'(req_rdy), 32'h08);
      @(negedge clk);
      out_rdy = 1'b0;
      #1;
      chk("mr_vld_pre", 32'(out_vld), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mr_vld_rst", 32'(out_vld), 32'd0);
      chk("mr_pkt_rst", 32'(out_pkt), 32'd0);
      chk("mr_rdy_rst", 32'(req_rdy), 32'd0);
      @(negedge clk);
      rst_n   = 1'b1;
      out_rdy = 1'b1;
      req_vld = 5'b01100;
      #1;
      chk("mr_after_rdy", 32'(req_rdy), 32'h04);
      @(negedge clk);
      #1;
      chk("mr_after_vld", 32'(out_vld), 32'd1);
      chk("mr_after_src", 32'(out_src), 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
